// File: rtl/tdc_pulse_gen.sv
// Burst generator of start/stop pulse pairs for TDC calibration and self-test.
// Programmable start-to-stop delay, pulse width, inter-pair gap and pair count.
module tdc_pulse_gen #(
  parameter int CNT_W  = 8,
  parameter int SHOT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              trig,
  input  logic              abort,
  input  logic [CNT_W-1:0]  delay_cfg,
  input  logic [CNT_W-1:0]  width_cfg,
  input  logic [CNT_W-1:0]  gap_cfg,
  input  logic [SHOT_W-1:0] shots_cfg,
  output logic              start_out,
  output logic              stop_out,
  output logic              busy,
  output logic              done,
  output logic [SHOT_W-1:0] shot_cnt
);

  localparam int TW = CNT_W + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PULSE = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [TW-1:0]     t_q, t_d;
  logic [CNT_W-1:0]  gcnt_q, gcnt_d;
  logic [SHOT_W-1:0] shot_q, shot_d, shot_inc;
  logic              start_q, start_d, stop_q, stop_d;
  logic              busy_q, busy_d, done_q, done_d;

  logic [CNT_W-1:0]  d_q, w_q, g_q, d_nx, w_nx, g_nx;
  logic [SHOT_W-1:0] n_q, n_nx;
  logic              load;
  logic [TW-1:0]     last_t, dw_nx;

  function automatic logic [CNT_W-1:0] at_least_one(input logic [CNT_W-1:0] v);
    return (v == '0) ? CNT_W'(1) : v;
  endfunction

  always_comb begin
    load     = (state_q == S_IDLE) && trig && !abort;
    d_nx     = load ? at_least_one(delay_cfg) : d_q;
    w_nx     = load ? at_least_one(width_cfg) : w_q;
    g_nx     = load ? gap_cfg : g_q;
    n_nx     = load ? shots_cfg : n_q;
    last_t   = {1'b0, d_q} + {1'b0, w_q} - TW'(1);
    shot_inc = shot_q + SHOT_W'(1);

    state_d = state_q;
    t_d     = t_q;
    gcnt_d  = gcnt_q;
    shot_d  = shot_q;

    case (state_q)
      S_IDLE: begin
        if (load) begin
          shot_d  = '0;
          t_d     = '0;
          state_d = (n_nx == '0) ? S_DONE : S_PULSE;
        end
      end
      S_PULSE: begin
        if (t_q == last_t) begin
          shot_d = shot_inc;
          t_d    = '0;
          if (shot_inc == n_q) begin
            state_d = S_DONE;
          end else if (g_q != '0) begin
            state_d = S_GAP;
            gcnt_d  = g_q - CNT_W'(1);
          end
        end else begin
          t_d = t_q + TW'(1);
        end
      end
      S_GAP: begin
        if (gcnt_q == '0) begin
          state_d = S_PULSE;
          t_d     = '0;
        end else begin
          gcnt_d = gcnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort wins over every transition but keeps the completed-pair count.
    if (abort) begin
      state_d = S_IDLE;
      shot_d  = shot_q;
    end

    // Outputs are decoded from next-state values so they can be registered
    // without adding a cycle of latency after the trigger.
    dw_nx   = {1'b0, d_nx} + {1'b0, w_nx};
    start_d = (state_d == S_PULSE) && (t_d < {1'b0, w_nx});
    stop_d  = (state_d == S_PULSE) && (t_d >= {1'b0, d_nx}) && (t_d < dw_nx);
    busy_d  = (state_d == S_PULSE) || (state_d == S_GAP);
    done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= S_IDLE;
      t_q     <= '0;
      gcnt_q  <= '0;
      shot_q  <= '0;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      gcnt_q  <= gcnt_d;
      shot_q  <= shot_d;
      start_q <= start_d;
      stop_q  <= stop_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Configuration snapshot is pure data and is only ever read after a load.
  always_ff @(posedge clk) begin
    if (load) begin
      d_q <= d_nx;
      w_q <= w_nx;
      g_q <= g_nx;
      n_q <= n_nx;
    end
  end

  assign start_out = start_q;
  assign stop_out  = stop_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign shot_cnt  = shot_q;

endmodule

// File: doc/tdc_pulse_gen.md
# tdc_pulse_gen

Digital-to-time stimulus generator: on a trigger it emits a burst of `start_out`/`stop_out` pulse pairs with a programmable start-to-stop interval, pulse width, inter-pair gap and pair count, all in clock cycles. It drives the start and stop inputs of the delay-line TDC for on-chip calibration and self-test. It also reports burst progress to the readout logic.

## Interface

Parameters:

- `CNT_W`, 8: width of the delay, width and gap configuration fields.
- `SHOT_W`, 8: width of the pair-count field and of the completed-pair counter.

Ports:

- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-high reset. A high level resets the block immediately; the port keeps the codebase name.
- `trig`  in  1  burst request; sampled each cycle; accepted only in IDLE.
- `abort`  in  1  cancels any burst in progress.
- `delay_cfg`  in  CNT_W  start-rise to stop-rise distance D in cycles; 0 is treated as 1.
- `width_cfg`  in  CNT_W  high time W of each start and stop pulse; 0 is treated as 1.
- `gap_cfg`  in  CNT_W  low cycles G between the end of one pair and the next start; 0 is allowed.
- `shots_cfg`  in  SHOT_W  number of pairs N in a burst; 0 is allowed.
- `start_out`  out  1  registered start pulse.
- `stop_out`  out  1  registered stop pulse.
- `busy`  out  1  high while the block is in the PULSE or GAP state.
- `done`  out  1  one-cycle strobe when a burst completes normally.
- `shot_cnt`  out  SHOT_W  pairs completed in the current or last burst.

## Operation

States:

- **IDLE.** If `trig`=1 and `abort`=0, latch D, W, G and N, clear `shot_cnt` and the phase counter t.
  - If N=0, go to DONE.
  - Otherwise go to PULSE.
- **PULSE.** Phase counter t runs 0 .. D+W-1 (width CNT_W+1, no overflow possible).
  - `start_out` = (t < W).
  - `stop_out` = (D <= t < D+W).
  - start and stop may overlap when D < W.
  - On t = D+W-1: increment `shot_cnt`.
    - If `shot_cnt`+1 = N, go to DONE.
    - Else if G=0, restart PULSE at t=0.
    - Else go to GAP.
- **GAP.** Both pulse outputs low for exactly G cycles, then PULSE with t=0.
- **DONE.** `done`=1 and `busy`=0 for one cycle, then IDLE. `trig` is ignored in DONE.

Rules:

- Configuration is latched only at trigger acceptance. Input changes during a burst have no effect.
- `trig` is ignored in PULSE, GAP and DONE. There is no queuing of triggers.
- `abort` has priority over everything except reset.
  - In any state, the next cycle is IDLE with `start_out`=`stop_out`=`busy`=0 and no `done` strobe.
  - `shot_cnt` holds its value.
  - `abort` with `trig` in the same IDLE cycle: the trigger is not accepted.
- Reset (`rst_n`=1) sets the state to IDLE and `start_out`=`stop_out`=`busy`=`done`=0, `shot_cnt`=0, with no clock required. This applies mid-burst as well.
- `shot_cnt` never exceeds N (at most 2^SHOT_W-1) and cannot wrap.

## Timing

- All outputs are registered; there are no combinational paths from inputs to outputs.
- A trigger sampled at edge k gives `start_out` high from cycle k+1 (t=0). Latency is 1 cycle.
- Pair length is D+W cycles. The burst period per pair is D+W+G, except after the last pair, which has no trailing gap.
- `done` is asserted in the cycle immediately after the final stop-pulse cycle. With N=0, `done` is asserted in cycle k+1.
- The earliest new trigger is accepted in the cycle after DONE.
- `shot_cnt` updates in the cycle after the final cycle of each pair.

## Test plan

- **Basic burst.** D=3, W=2, G=1, N=2, `trig` sampled at cycle 0 → `start_out` high in cycles 1-2 and 7-8; `stop_out` high in 4-5 and 10-11; both low in cycle 6; `done` in cycle 12; `shot_cnt`=2; `busy` high in cycles 1-11.
- **Overlap.** D=1, W=4, G=0, N=1 → `start_out` high in 1-4, `stop_out` high in 2-5, `done` in 6, `shot_cnt`=1.
- **Zero fields.** D=0, W=0, G=0, N=3 → `start_out` high in 1, 3, 5; `stop_out` high in 2, 4, 6; `done` in 7; `shot_cnt`=3.
- **N=0.** `trig` at cycle 0 → `done` in cycle 1; `start_out`, `stop_out` and `busy` never high; `shot_cnt`=0.
- **Abort and busy trigger.** D=4, W=4, G=2, N=5 with `abort` pulsed at cycle 10:
  - Outputs low and state IDLE from cycle 11; no `done`; `shot_cnt`=1.
  - A `trig` at cycle 5 is ignored.
  - A `trig` at cycle 11 starts a new burst with `start_out` high at cycle 12.
- **Reset mid-burst.** `rst_n`=1 asynchronously during PULSE → all outputs 0 immediately. After release, `trig` gives `start_out` high exactly one cycle after it is sampled.
